imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
Shares the single-port, synchronous-read instruction memory between the pipeline fetch stage and the debug/program-loader port. Each cycle it grants at most one access and returns read data one cycle later. A debug halt handshake drains fetch traffic so the loader can rewrite program memory safely. It sits between the IF stage, the debug unit and the instruction memory macro.

Parameters:
MEM_SIZE, 20, memory depth in 32-bit words
IDX_W, $clog2(MEM_SIZE), width of the memory word index
MAX_WAIT, 4, cycles a pending debug request may lose to fetch before it is forced through
NOP_INSTR, 32'h00000013, data returned for out-of-range reads

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch read request
fetch_addr  in  32  fetch byte address
fetch_gnt  out  1  fetch request accepted this cycle (combinational)
fetch_rvalid  out  1  fetch read data valid (one cycle after grant)
fetch_rdata  out  32  fetch read data
dbg_req  in  1  debug access request
dbg_we  in  1  debug write (1) or read (0)
dbg_addr  in  32  debug byte address
dbg_wdata  in  32  debug write data
dbg_gnt  out  1  debug request accepted this cycle (combinational)
dbg_rvalid  out  1  debug response valid (reads and writes)
dbg_rdata  out  32  debug read data (0 for writes)
dbg_err  out  1  with dbg_rvalid: access was misaligned or out of range
halt_req  in  1  debug requests fetch halt (level)
halted  out  1  fetch is halted and drained
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  IDX_W  word index = addr[IDX_W+1:2]
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (async, rst_n=0): state RUN, wait_cnt=0, response pipe empty. All outputs 0. Any in-flight response is discarded; no rvalid is issued after reset release for a pre-reset grant.
- FSM states and transitions:
  - RUN -> DRAIN when halt_req=1.
  - DRAIN -> HALTED when no fetch response is outstanding; otherwise stay in DRAIN one more cycle.
  - DRAIN -> RUN if halt_req falls.
  - HALTED -> RUN the cycle after halt_req=0.
- halted=1 only in HALTED, and is registered.
- Fetch grants are issued only in RUN. Debug may be granted in any state.
- Arbitration in RUN:
  - Only fetch_req: fetch wins.
  - Only dbg_req: debug wins.
  - Both: fetch wins unless wait_cnt==MAX_WAIT, in which case debug wins.
- wait_cnt: +1 each cycle dbg_req=1 and dbg_gnt=0, saturating at MAX_WAIT. Cleared on dbg_gnt or dbg_req=0.
- Granted cycle:
  - mem_en=1 and mem_addr=word index.
  - mem_we=dbg_we for debug grants, 0 for fetch grants.
  - mem_wdata=dbg_wdata.
  - The owner, op type and error flag are registered.
- Out-of-range (word index >= MEM_SIZE):
  - Still granted, but mem_en=0 (memory untouched).
  - Read returns NOP_INSTR.
  - dbg_err=1 for a debug access; fetch gets NOP_INSTR with no error.
- Misaligned address (addr[1:0]!=0):
  - Fetch: low bits ignored.
  - Debug: mem_en=0, dbg_err=1, dbg_rdata=0.
- Response latency is exactly 1 cycle after the grant, as a one-cycle pulse to the owner only.
  - rdata=mem_rdata for an in-range read.
  - dbg_rdata=0 for writes.
  - The non-owner's rdata holds 0.
- Throughput is one access per cycle, back-to-back, no bubbles.

Test Plan:
- Reset then fetch_req with fetch_addr 0,4,8 on consecutive cycles (mem word k = 0x100+k) -> fetch_gnt=1 each cycle; fetch_rvalid on cycles 2..4 with rdata 0x100, 0x101, 0x102.
- fetch_req and dbg_req held high together, MAX_WAIT=4 -> fetch granted 4 cycles, debug granted on the 5th, then fetch resumes; wait_cnt back to 0.
- halt_req=1 while fetch streaming -> no fetch_gnt from the next cycle; halted=1 after the outstanding response. Debug write 0xDEADBEEF to addr 0x8, halt_req=0, fetch addr 0x8 -> fetch_rdata=0xDEADBEEF.
- Debug read addr 0x50 (index 20 >= MEM_SIZE) -> mem_en=0, dbg_rvalid with dbg_err=1. Fetch addr 0x50 -> fetch_rdata=0x00000013, no error.
- Debug read addr 0x6 -> dbg_err=1, dbg_rdata=0, memory not accessed.
- Assert rst_n=0 on the cycle after a fetch grant -> outputs 0 immediately; no fetch_rvalid after release; state RUN.

Source files
------------

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between instruction fetch and the debug/loader
// port, with a halt handshake that drains fetch traffic before the loader rewrites memory.
module imem_arbiter #(
  parameter int unsigned MEM_SIZE  = 20,
  parameter int unsigned IDX_W     = $clog2(MEM_SIZE),
  parameter int unsigned MAX_WAIT  = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic             fetch_gnt,
  output logic             fetch_rvalid,
  output logic [31:0]      fetch_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  output logic             dbg_gnt,
  output logic             dbg_rvalid,
  output logic [31:0]      dbg_rdata,
  output logic             dbg_err,
  input  logic             halt_req,
  output logic             halted,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;
  typedef enum logic [1:0] {SelZero, SelMem, SelNop} rsel_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             halted_q;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_dbg_q, resp_dbg_d;
  logic             resp_err_q, resp_err_d;
  rsel_e            resp_sel_q, resp_sel_d;

  logic             fetch_oor, dbg_oor, dbg_misal;
  logic             fetch_ok, dbg_force, dbg_access_ok;
  logic [31:0]      resp_data;
  logic             unused_fetch_lsb;

  // Range is judged on the full word address so aliases above the index width are rejected too.
  assign fetch_oor        = fetch_addr[31:2] >= 30'(MEM_SIZE);
  assign dbg_oor          = dbg_addr[31:2] >= 30'(MEM_SIZE);
  assign dbg_misal        = dbg_addr[1:0] != 2'b00;
  assign dbg_access_ok    = !dbg_oor && !dbg_misal;
  assign unused_fetch_lsb = ^fetch_addr[1:0];

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign fetch_ok  = fetch_req && (state_q == StRun);
  assign dbg_force = dbg_req && (wait_cnt_q == CNT_W'(MAX_WAIT));
  assign dbg_gnt   = rst_n && dbg_req && (!fetch_ok || dbg_force);
  assign fetch_gnt = rst_n && fetch_ok && !dbg_force;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_en    = dbg_access_ok;
      mem_we    = dbg_access_ok && dbg_we;
      mem_addr  = dbg_addr[IDX_W+1:2];
      mem_wdata = dbg_wdata;
    end else if (fetch_gnt) begin
      mem_en    = !fetch_oor;
      mem_addr  = fetch_addr[IDX_W+1:2];
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    resp_valid_d = dbg_gnt || fetch_gnt;
    resp_dbg_d   = dbg_gnt;
    resp_err_d   = 1'b0;
    resp_sel_d   = SelZero;
    if (dbg_gnt) begin
      resp_err_d = !dbg_access_ok;
      if (dbg_misal || dbg_we) begin
        resp_sel_d = SelZero;
      end else if (dbg_oor) begin
        resp_sel_d = SelNop;
      end else begin
        resp_sel_d = SelMem;
      end
    end else if (fetch_gnt) begin
      resp_sel_d = fetch_oor ? SelNop : SelMem;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req || dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // A fetch response presented this cycle still counts as outstanding while draining.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (halt_req) state_d = StDrain;
      end
      StDrain: begin
        if (!halt_req) begin
          state_d = StRun;
        end else if (!(resp_valid_q && !resp_dbg_q)) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (!halt_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      halted_q     <= 1'b0;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_dbg_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_sel_q   <= SelZero;
    end else begin
      state_q      <= state_d;
      halted_q     <= (state_d == StHalted);
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_dbg_q   <= resp_dbg_d;
      resp_err_q   <= resp_err_d;
      resp_sel_q   <= resp_sel_d;
    end
  end

  always_comb begin
    resp_data = '0;
    unique case (resp_sel_q)
      SelMem:  resp_data = mem_rdata;
      SelNop:  resp_data = NOP_INSTR;
      default: resp_data = '0;
    endcase
  end

  assign fetch_rvalid = resp_valid_q && !resp_dbg_q;
  assign dbg_rvalid   = resp_valid_q && resp_dbg_q;
  assign fetch_rdata  = fetch_rvalid ? resp_data : '0;
  assign dbg_rdata    = dbg_rvalid ? resp_data : '0;
  assign dbg_err      = dbg_rvalid && resp_err_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus pushes expected responses, a negedge monitor
// pops and compares them against fetch/debug responses, including their one-cycle latency.
module tb_imem_arbiter;

  localparam int unsigned MEM_SIZE = 20;
  localparam int unsigned IDX_W    = $clog2(MEM_SIZE);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fetch_req, fetch_gnt, fetch_rvalid;
  logic [31:0]      fetch_addr, fetch_rdata;
  logic             dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0]      dbg_addr, dbg_wdata, dbg_rdata;
  logic             halt_req, halted;
  logic             mem_en, mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata, mem_rdata;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        fq[$];
  exp_t        dq[$];
  exp_t        fe, de;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem[MEM_SIZE];
  logic        done;

  imem_arbiter #(
    .MEM_SIZE (MEM_SIZE),
    .MAX_WAIT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .dbg_err      (dbg_err),
    .halt_req     (halt_req),
    .halted       (halted),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory macro model.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle, checks grants and mem_en, and queues the expected responses.
  task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic efg,
                       input logic edg, input logic emen, input logic [31:0] ef,
                       input logic [31:0] ed, input logic ee, input string name);
    exp_t e;
    fetch_req  = fr;
    fetch_addr = fa;
    dbg_req    = dr;
    dbg_we     = dw;
    dbg_addr   = da;
    dbg_wdata  = dd;
    @(negedge clk);
    chk1({name, "_fetch_gnt"}, fetch_gnt, efg);
    chk1({name, "_dbg_gnt"}, dbg_gnt, edg);
    chk1({name, "_mem_en"}, mem_en, emen);
    if (efg) begin
      e.data = ef; e.err = 1'b0; e.cyc = cyc + 1;
      fq.push_back(e);
    end
    if (edg) begin
      e.data = ed; e.err = ee; e.cyc = cyc + 1;
      dq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "idle");
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fetch_rvalid) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected_rvalid: got rdata %h expected no response", fetch_rdata);
        end else begin
          fe = fq.pop_front();
          chk("fetch_rdata", fetch_rdata, fe.data);
          chk("fetch_latency", cyc, fe.cyc);
        end
        chk("dbg_rdata_nonowner", dbg_rdata, 32'h0);
      end
      if (dbg_rvalid) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dbg_unexpected_rvalid: got rdata %h expected no response", dbg_rdata);
        end else begin
          de = dq.pop_front();
          chk("dbg_rdata", dbg_rdata, de.data);
          chk1("dbg_err", dbg_err, de.err);
          chk("dbg_latency", cyc, de.cyc);
        end
        chk("fetch_rdata_nonowner", fetch_rdata, 32'h0);
      end
    end
  end

  initial begin
    for (int k = 0; k < int'(MEM_SIZE); k++) mem[k] = 32'h100 + k;
    mem_rdata  = 32'h0;
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    dbg_req    = 1'b0;
    dbg_we     = 1'b0;
    dbg_addr   = 32'h0;
    dbg_wdata  = 32'h0;
    halt_req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_fetch_rvalid", fetch_rvalid, 1'b0);
    chk1("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back fetch stream.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0, "f0");
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 1'b0, "f4");
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 1'b0, "f8");
    idle(1);

    // Contention: fetch wins four times, then debug is forced through; twice to show the reset.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 32'hC, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 1'b0,
              "cont_f");
      end
      drive(1'b1, 32'hC, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h104, 1'b0,
            "cont_d");
    end
    drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 1'b0, "resume");
    idle(1);

    // Halt while streaming, then load a word and fetch it back.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0, "hs0");
    halt_req = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0, "hs1");
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      chk1("drain_fetch_gnt", fetch_gnt, 1'b0);
      if (halted) done = 1'b1;
      @(posedge clk);
      #1;
    end
    chk1("halted_reached", done, 1'b1);
    drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0,
          "ld_wr");
    halt_req = 1'b0;
    idle(1);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0,
          "ld_rd");

    // Out-of-range and misaligned accesses.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, NOP, 1'b1, "d_oor");
    drive(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, NOP, 32'h0, 1'b0, "f_oor");
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h6, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, "d_mis");
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h50, 32'h1234, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1,
          "d_oor_wr");
    drive(1'b1, 32'h9, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0,
          "f_mis");
    // Debug write immediately followed by a fetch of the same word.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h55, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, "d_wr5");
    drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h55, 32'h0, 1'b0, "f_rd5");
    idle(1);

    // Reset the cycle after a fetch grant: the response must never appear.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    dbg_req    = 1'b1;
    dbg_addr   = 32'h10;
    @(negedge clk);
    chk1("pre_rst_fetch_gnt", fetch_gnt, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_fetch_gnt", fetch_gnt, 1'b0);
    chk1("mid_rst_dbg_gnt", dbg_gnt, 1'b0);
    chk1("mid_rst_fetch_rvalid", fetch_rvalid, 1'b0);
    chk1("mid_rst_mem_en", mem_en, 1'b0);
    chk1("mid_rst_halted", halted, 1'b0);
    fetch_req = 1'b0;
    dbg_req   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 1'b0, "post_rst");
    idle(2);

    chk("fetch_queue_empty", 32'(fq.size()), 32'h0);
    chk("dbg_queue_empty", 32'(dq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
